// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared codes for the MIPS control pipeline (MemtoReg, RegDst, fwd).
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int REG_AW_DFLT = 5;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC8 = 2'b10
    } memtoreg_e;

    typedef enum logic [1:0] {
        RDST_RT = 2'b00,
        RDST_RD = 2'b01,
        RDST_RA = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_if
// Brief    : ID control bundle in, staged controls / hazard selects out.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
);
    logic              RegWrite_id;
    logic              MemWrite_id;
    logic              ALUSrc_id;
    logic              Branch_id;
    logic              jr_id;
    logic [1:0]        MemtoReg_id;
    logic [1:0]        ALUop_id;
    logic [1:0]        RegDst_id;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic [REG_AW-1:0] rd_id;
    logic              use_rs_id;
    logic              use_rt_id;

    logic              stall;
    logic              RegWrite_ex;
    logic              RegWrite_mem;
    logic              RegWrite_wb;
    logic              MemWrite_mem;
    logic              ALUSrc_ex;
    logic [1:0]        ALUop_ex;
    logic [1:0]        MemtoReg_wb;
    logic [REG_AW-1:0] a3_ex;
    logic [REG_AW-1:0] a3_mem;
    logic [REG_AW-1:0] a3_wb;
    logic [1:0]        fwd_a_ex;
    logic [1:0]        fwd_b_ex;
    logic              fwd_rs_id;
    logic              fwd_rt_id;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output RegWrite_id, MemWrite_id, ALUSrc_id, Branch_id, jr_id,
               MemtoReg_id, ALUop_id, RegDst_id, rs_id, rt_id, rd_id,
               use_rs_id, use_rt_id,
        input  stall, RegWrite_ex, RegWrite_mem, RegWrite_wb, MemWrite_mem,
               ALUSrc_ex, ALUop_ex, MemtoReg_wb, a3_ex, a3_mem, a3_wb,
               fwd_a_ex, fwd_b_ex, fwd_rs_id, fwd_rt_id, stall_cnt
    );

    modport slave (
        input  RegWrite_id, MemWrite_id, ALUSrc_id, Branch_id, jr_id,
               MemtoReg_id, ALUop_id, RegDst_id, rs_id, rt_id, rd_id,
               use_rs_id, use_rt_id,
        output stall, RegWrite_ex, RegWrite_mem, RegWrite_wb, MemWrite_mem,
               ALUSrc_ex, ALUop_ex, MemtoReg_wb, a3_ex, a3_mem, a3_wb,
               fwd_a_ex, fwd_b_ex, fwd_rs_id, fwd_rt_id, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_hazard
// Brief    : Combinational load-use / ID-branch stall and forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_hazard #(
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] i_rs_id,
    input  wire logic [REG_AW-1:0] i_rt_id,
    input  wire logic              i_use_rs_id,
    input  wire logic              i_use_rt_id,
    input  wire logic              i_branch_id,
    input  wire logic              i_jr_id,
    input  wire logic              i_regwrite_ex,
    input  wire logic [1:0]        i_memtoreg_ex,
    input  wire logic [REG_AW-1:0] i_a3_ex,
    input  wire logic [REG_AW-1:0] i_rs_ex,
    input  wire logic [REG_AW-1:0] i_rt_ex,
    input  wire logic              i_regwrite_mem,
    input  wire logic [1:0]        i_memtoreg_mem,
    input  wire logic [REG_AW-1:0] i_a3_mem,
    input  wire logic              i_regwrite_wb,
    input  wire logic [REG_AW-1:0] i_a3_wb,
    output logic                   o_stall,
    output logic [1:0]             o_fwd_a_ex,
    output logic [1:0]             o_fwd_b_ex,
    output logic                   o_fwd_rs_id,
    output logic                   o_fwd_rt_id
);
    import mips_ctrl_pkg::*;

    logic w_id_hit_ex;
    logic w_id_hit_mem;
    logic w_ex_load;
    logic w_mem_load;
    logic w_id_early;
    logic w_mem_wr;
    logic w_wb_wr;

    always_comb begin
        w_ex_load  = (i_memtoreg_ex  == M2R_MEM);
        w_mem_load = (i_memtoreg_mem == M2R_MEM);
        w_id_early = i_branch_id | i_jr_id;
        // $0 is excluded from every match so it can never stall or forward
        w_id_hit_ex  = (i_a3_ex != '0) &&
                       ((i_use_rs_id && (i_rs_id == i_a3_ex)) ||
                        (i_use_rt_id && (i_rt_id == i_a3_ex)));
        w_id_hit_mem = (i_a3_mem != '0) &&
                       ((i_use_rs_id && (i_rs_id == i_a3_mem)) ||
                        (i_use_rt_id && (i_rt_id == i_a3_mem)));
        w_mem_wr = i_regwrite_mem && (i_a3_mem != '0);
        w_wb_wr  = i_regwrite_wb  && (i_a3_wb  != '0);

        o_stall = (w_ex_load && w_id_hit_ex) ||
                  (w_id_early && i_regwrite_ex && w_id_hit_ex) ||
                  (w_id_early && w_mem_load && w_id_hit_mem);

        o_fwd_a_ex = FWD_RF;
        if (w_mem_wr && (i_a3_mem == i_rs_ex))
            o_fwd_a_ex = FWD_MEM;
        else if (w_wb_wr && (i_a3_wb == i_rs_ex))
            o_fwd_a_ex = FWD_WB;

        o_fwd_b_ex = FWD_RF;
        if (w_mem_wr && (i_a3_mem == i_rt_ex))
            o_fwd_b_ex = FWD_MEM;
        else if (w_wb_wr && (i_a3_wb == i_rt_ex))
            o_fwd_b_ex = FWD_WB;

        // a load in MEM has no result yet; those cases are covered by stall
        o_fwd_rs_id = w_mem_wr && !w_mem_load && (i_a3_mem == i_rs_id);
        o_fwd_rt_id = w_mem_wr && !w_mem_load && (i_a3_mem == i_rt_id);
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Brief    : EX/MEM/WB control pipeline with destination resolve and hazards.
//            Optional stall counter enabled by CTRL_PIPE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 32
) (
    input  wire logic  clk,
    input  wire logic  reset,
    ctrl_pipe_if.slave bus
);
    import mips_ctrl_pkg::*;

    logic [REG_AW-1:0] w_a3_id;
    logic              w_stall;

    logic              r_regwrite_ex;
    logic              r_memwrite_ex;
    logic              r_alusrc_ex;
    logic [1:0]        r_memtoreg_ex;
    logic [1:0]        r_aluop_ex;
    logic [REG_AW-1:0] r_a3_ex;
    logic [REG_AW-1:0] r_rs_ex;
    logic [REG_AW-1:0] r_rt_ex;

    logic              r_regwrite_mem;
    logic              r_memwrite_mem;
    logic [1:0]        r_memtoreg_mem;
    logic [REG_AW-1:0] r_a3_mem;

    logic              r_regwrite_wb;
    logic [1:0]        r_memtoreg_wb;
    logic [REG_AW-1:0] r_a3_wb;

    always_comb begin
        w_a3_id = '0;
        if (bus.RegWrite_id) begin
            case (bus.RegDst_id)
                RDST_RT: w_a3_id = bus.rt_id;
                RDST_RD: w_a3_id = bus.rd_id;
                RDST_RA: w_a3_id = REG_AW'(31);
                default: w_a3_id = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite_ex  <= 1'b0;
            r_memwrite_ex  <= 1'b0;
            r_alusrc_ex    <= 1'b0;
            r_memtoreg_ex  <= '0;
            r_aluop_ex     <= '0;
            r_a3_ex        <= '0;
            r_rs_ex        <= '0;
            r_rt_ex        <= '0;
            r_regwrite_mem <= 1'b0;
            r_memwrite_mem <= 1'b0;
            r_memtoreg_mem <= '0;
            r_a3_mem       <= '0;
            r_regwrite_wb  <= 1'b0;
            r_memtoreg_wb  <= '0;
            r_a3_wb        <= '0;
        end else begin
            // a stall holds IF/ID externally and injects an all-zero bubble here
            r_regwrite_ex  <= w_stall ? 1'b0 : bus.RegWrite_id;
            r_memwrite_ex  <= w_stall ? 1'b0 : bus.MemWrite_id;
            r_alusrc_ex    <= w_stall ? 1'b0 : bus.ALUSrc_id;
            r_memtoreg_ex  <= w_stall ? 2'b00 : bus.MemtoReg_id;
            r_aluop_ex     <= w_stall ? 2'b00 : bus.ALUop_id;
            r_a3_ex        <= w_stall ? '0 : w_a3_id;
            r_rs_ex        <= w_stall ? '0 : bus.rs_id;
            r_rt_ex        <= w_stall ? '0 : bus.rt_id;
            r_regwrite_mem <= r_regwrite_ex;
            r_memwrite_mem <= r_memwrite_ex;
            r_memtoreg_mem <= r_memtoreg_ex;
            r_a3_mem       <= r_a3_ex;
            r_regwrite_wb  <= r_regwrite_mem;
            r_memtoreg_wb  <= r_memtoreg_mem;
            r_a3_wb        <= r_a3_mem;
        end
    end

    ctrl_hazard #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_rs_id        (bus.rs_id),
        .i_rt_id        (bus.rt_id),
        .i_use_rs_id    (bus.use_rs_id),
        .i_use_rt_id    (bus.use_rt_id),
        .i_branch_id    (bus.Branch_id),
        .i_jr_id        (bus.jr_id),
        .i_regwrite_ex  (r_regwrite_ex),
        .i_memtoreg_ex  (r_memtoreg_ex),
        .i_a3_ex        (r_a3_ex),
        .i_rs_ex        (r_rs_ex),
        .i_rt_ex        (r_rt_ex),
        .i_regwrite_mem (r_regwrite_mem),
        .i_memtoreg_mem (r_memtoreg_mem),
        .i_a3_mem       (r_a3_mem),
        .i_regwrite_wb  (r_regwrite_wb),
        .i_a3_wb        (r_a3_wb),
        .o_stall        (w_stall),
        .o_fwd_a_ex     (bus.fwd_a_ex),
        .o_fwd_b_ex     (bus.fwd_b_ex),
        .o_fwd_rs_id    (bus.fwd_rs_id),
        .o_fwd_rt_id    (bus.fwd_rt_id)
    );

    assign bus.stall        = w_stall;
    assign bus.RegWrite_ex  = r_regwrite_ex;
    assign bus.RegWrite_mem = r_regwrite_mem;
    assign bus.RegWrite_wb  = r_regwrite_wb;
    assign bus.MemWrite_mem = r_memwrite_mem;
    assign bus.ALUSrc_ex    = r_alusrc_ex;
    assign bus.ALUop_ex     = r_aluop_ex;
    assign bus.MemtoReg_wb  = r_memtoreg_wb;
    assign bus.a3_ex        = r_a3_ex;
    assign bus.a3_mem       = r_a3_mem;
    assign bus.a3_wb        = r_a3_wb;

`ifdef CTRL_PIPE_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Randomized scoreboard bench for ctrl_pipe against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int AW     = 5;
    localparam int SW     = 32;
    localparam int NCYC   = 3000;

    typedef struct {
        bit        rw;
        bit        mw;
        bit        alusrc;
        bit [1:0]  m2r;
        bit [1:0]  aluop;
        int        a3;
        int        rs;
        int        rt;
    } ins_t;

    typedef struct {
        logic        stall;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        frs;
        logic        frt;
        logic [23:0] staged;
        logic [SW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_AW(AW), .STAT_W(SW)) bus ();

    ctrl_pipe #(.REG_AW(AW), .STAT_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per presented cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [23:0] act_st;
            e = exp_q.pop_front();
            act_st = {bus.RegWrite_ex, bus.RegWrite_mem, bus.RegWrite_wb, bus.MemWrite_mem,
                      bus.ALUSrc_ex, bus.ALUop_ex, bus.MemtoReg_wb,
                      bus.a3_ex, bus.a3_mem, bus.a3_wb};
            check("stall",     64'(bus.stall),     64'(e.stall));
            check("fwd_a_ex",  64'(bus.fwd_a_ex),  64'(e.fa));
            check("fwd_b_ex",  64'(bus.fwd_b_ex),  64'(e.fb));
            check("fwd_rs_id", 64'(bus.fwd_rs_id), 64'(e.frs));
            check("fwd_rt_id", 64'(bus.fwd_rt_id), 64'(e.frt));
            check("staged",    64'(act_st),        64'(e.staged));
            check("stall_cnt", 64'(bus.stall_cnt), 64'(e.cnt));
        end
    end

    // Reference model: three in-flight instruction slots.
    ins_t m_ex, m_mem, m_wb, empty_i, id_i, prev_id;
    int unsigned m_cnt;
    bit id_br, id_jr, id_urs, id_urt;
    int id_rd;
    bit [1:0] id_rdst;

    function automatic bit id_reads(input int r);
        return (r != 0) && ((id_urs && id_i.rs == r) || (id_urt && id_i.rt == r));
    endfunction

    function automatic logic [1:0] fwd_sel(input int src);
        if (m_mem.rw && m_mem.a3 != 0 && m_mem.a3 == src) return 2'b01;
        if (m_wb.rw && m_wb.a3 != 0 && m_wb.a3 == src)    return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic id_fwd(input int src);
        return m_mem.rw && m_mem.a3 != 0 && m_mem.m2r != 2'b01 && m_mem.a3 == src;
    endfunction

    initial begin
        bit   prev_reset;
        bit   prev_stall;
        bit   did_rst_stall;
        bit   load_ex, early;
        exp_t e;

        empty_i = '{rw:0, mw:0, alusrc:0, m2r:0, aluop:0, a3:0, rs:0, rt:0};
        id_i = empty_i; prev_id = empty_i;
        m_ex = empty_i; m_mem = empty_i; m_wb = empty_i; m_cnt = 0;
        id_br = 0; id_jr = 0; id_urs = 0; id_urt = 0; id_rd = 0; id_rdst = 0;
        bus.RegWrite_id = 0; bus.MemWrite_id = 0; bus.ALUSrc_id = 0; bus.Branch_id = 0;
        bus.jr_id = 0; bus.MemtoReg_id = 0; bus.ALUop_id = 0; bus.RegDst_id = 0;
        bus.rs_id = 0; bus.rt_id = 0; bus.rd_id = 0; bus.use_rs_id = 0; bus.use_rt_id = 0;
        prev_reset = 1; prev_stall = 0; did_rst_stall = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // Advance model by the edge just taken.
            if (prev_reset) begin
                m_ex = empty_i; m_mem = empty_i; m_wb = empty_i; m_cnt = 0;
            end else begin
                if (prev_stall) m_cnt++;
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = prev_stall ? empty_i : prev_id;
            end
            reset = 0;

            // IF/ID holds its instruction while stalled.
            if (prev_reset || !prev_stall) begin
                id_i.rw     = ($urandom_range(0, 3) != 0);
                id_i.mw     = $urandom_range(0, 1);
                id_i.alusrc = $urandom_range(0, 1);
                id_i.m2r    = 2'($urandom_range(0, 2));
                id_i.aluop  = 2'($urandom_range(0, 3));
                id_i.rs     = $urandom_range(0, 3);
                id_i.rt     = $urandom_range(0, 3);
                id_rd       = $urandom_range(0, 3);
                id_rdst     = 2'($urandom_range(0, 2));
                id_urs      = $urandom_range(0, 1);
                id_urt      = $urandom_range(0, 1);
                id_br       = ($urandom_range(0, 3) == 0);
                id_jr       = ($urandom_range(0, 5) == 0);
                if (!id_i.rw)          id_i.a3 = 0;
                else if (id_rdst == 0) id_i.a3 = id_i.rt;
                else if (id_rdst == 1) id_i.a3 = id_rd;
                else                   id_i.a3 = 31;
            end
            bus.RegWrite_id = id_i.rw;     bus.MemWrite_id = id_i.mw;
            bus.ALUSrc_id   = id_i.alusrc; bus.MemtoReg_id = id_i.m2r;
            bus.ALUop_id    = id_i.aluop;  bus.RegDst_id   = id_rdst;
            bus.rs_id = AW'(id_i.rs); bus.rt_id = AW'(id_i.rt); bus.rd_id = AW'(id_rd);
            bus.use_rs_id = id_urs; bus.use_rt_id = id_urt;
            bus.Branch_id = id_br;  bus.jr_id = id_jr;

            load_ex = (m_ex.m2r == 2'b01);
            early   = id_br || id_jr;
            e.stall = (load_ex && id_reads(m_ex.a3)) ||
                      (early && m_ex.rw && id_reads(m_ex.a3)) ||
                      (early && m_mem.m2r == 2'b01 && id_reads(m_mem.a3));
            e.fa  = fwd_sel(m_ex.rs);
            e.fb  = fwd_sel(m_ex.rt);
            e.frs = id_fwd(id_i.rs);
            e.frt = id_fwd(id_i.rt);
            e.staged = {m_ex.rw, m_mem.rw, m_wb.rw, m_mem.mw, m_ex.alusrc, m_ex.aluop,
                        m_wb.m2r, AW'(m_ex.a3), AW'(m_mem.a3), AW'(m_wb.a3)};
`ifdef CTRL_PIPE_STATS_EN
            e.cnt = SW'(m_cnt);
`else
            e.cnt = '0;
`endif
            exp_q.push_back(e);

            if (e.stall && !did_rst_stall && cyc > 1000) begin
                reset = 1; did_rst_stall = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1;
            end
            prev_reset = reset;
            prev_stall = e.stall;
            prev_id    = id_i;
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
